// File: rtl/audio_pkg.sv
// Shared types and constants for the audio capture path.
// PLAY_SHIFT mirrors the playback side's left shift so capture undoes it.
package audio_pkg;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } cap_state_t;

    localparam int SAMPLE_W      = 16;
    localparam int PLAY_SHIFT    = 14;
    localparam int DEFAULT_DEPTH = 10000;
endpackage

// File: rtl/audio_mix_sat.sv
// Mono downmix of a 32-bit stereo pair into one saturated 16-bit sample.
// ((L+R)>>>1)>>>PLAY_SHIFT is folded into one arithmetic shift of the 34-bit sum.
module audio_mix_sat
    import audio_pkg::*;
(
    input  logic [31:0]         i_left,
    input  logic [31:0]         i_right,
    output logic [SAMPLE_W-1:0] o_sample
);
    localparam logic signed [33:0] MAXV = 34'((1 << (SAMPLE_W - 1)) - 1);
    localparam logic signed [33:0] MINV = ~MAXV;

    logic signed [33:0] w_sum;
    logic signed [33:0] w_shift;

    assign w_sum   = $signed({{2{i_left[31]}}, i_left}) + $signed({{2{i_right[31]}}, i_right});
    assign w_shift = w_sum >>> (PLAY_SHIFT + 1);

    always_comb begin
        o_sample = w_shift[SAMPLE_W-1:0];
        if (w_shift > MAXV)
            o_sample = MAXV[SAMPLE_W-1:0];
        else if (w_shift < MINV)
            o_sample = MINV[SAMPLE_W-1:0];
    end
endmodule

// File: rtl/audio_capture.sv
// Captures decimated mono samples from the codec FIFO into a sample RAM.
// The codec is always drained; pairs are only kept while capturing.
module audio_capture
    import audio_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = 16,
    parameter int DECIM  = 1
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic                loop_en,
    input  logic                audio_in_available,
    input  logic [31:0]         left_channel_audio_in,
    input  logic [31:0]         right_channel_audio_in,
    output logic                read_audio_in,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [SAMPLE_W-1:0] mem_data,
    output logic                mem_wren,
    output logic [ADDR_W-1:0]   sample_count,
    output logic                busy,
    output logic                done
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] CNT_MAX   = ADDR_W'(DEPTH);
    localparam logic [15:0]       DEC_LAST  = 16'(DECIM - 1);

    cap_state_t          r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [SAMPLE_W-1:0] r_data;
    logic                r_wren;
    logic [ADDR_W-1:0]   r_count;
    logic [15:0]         r_dcnt;
    logic                r_busy;
    logic                r_done;

    logic [SAMPLE_W-1:0] w_sample;
    logic                w_last;

    audio_mix_sat u_mix (
        .i_left   (left_channel_audio_in),
        .i_right  (right_channel_audio_in),
        .o_sample (w_sample)
    );

    assign read_audio_in = audio_in_available & ~reset;
    // Reset in the write cycle must cancel the strobe already sitting in r_wren.
    assign mem_wren      = r_wren & ~reset;
    assign mem_address   = r_addr;
    assign mem_data      = r_data;
    assign sample_count  = r_count;
    assign busy          = r_busy;
    assign done          = r_done;

    // The write in flight is the final one of a one-shot capture.
    assign w_last = r_wren && (r_addr == LAST_ADDR) && !loop_en;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_data  <= '0;
            r_wren  <= 1'b0;
            r_count <= '0;
            r_dcnt  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_wren <= 1'b0;
            // Retire the write issued last cycle, even if stop/start lands now.
            if (r_wren) begin
                if (r_count != CNT_MAX)
                    r_count <= r_count + 1'b1;
                r_addr <= (r_addr == LAST_ADDR) ? '0 : r_addr + 1'b1;
            end
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start && !stop) begin
                        r_state <= ST_CAPTURE;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_addr  <= '0;
                        r_count <= '0;
                        r_dcnt  <= '0;
                    end
                end
                ST_CAPTURE: begin
                    if (stop) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (start) begin
                        r_addr  <= '0;
                        r_count <= '0;
                        r_dcnt  <= '0;
                    end else if (w_last) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (read_audio_in) begin
                        r_dcnt <= (r_dcnt == DEC_LAST) ? '0 : r_dcnt + 1'b1;
                        if (r_dcnt == '0) begin
                            r_data <= w_sample;
                            r_wren <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_audio_capture.sv
// Self-checking bench: three capture instances (one-shot, decimated, looping)
// with a write scoreboard per instance and table-driven mix vectors.
module tb_audio_capture;
    logic        clk = 1'b0;
    logic        reset, start_a, start_b, start_c, stop, loop_en, avail;
    logic [31:0] l_in, r_in;

    logic        rd_a, rd_b, rd_c, wren_a, wren_b, wren_c;
    logic        busy_a, busy_b, busy_c, done_a, done_b, done_c;
    logic [15:0] addr_a, addr_b, addr_c, data_a, data_b, data_c;
    logic [15:0] cnt_a, cnt_b, cnt_c;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        int          wcyc;
    } exp_t;

    typedef struct {
        logic [31:0] l;
        logic [31:0] r;
        logic [15:0] d;
    } vec_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];
    vec_t tbl[8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    audio_capture #(.DEPTH(8), .ADDR_W(16), .DECIM(1)) dut_a (
        .CLOCK_50(clk), .reset(reset), .start(start_a), .stop(stop), .loop_en(loop_en),
        .audio_in_available(avail), .left_channel_audio_in(l_in), .right_channel_audio_in(r_in),
        .read_audio_in(rd_a), .mem_address(addr_a), .mem_data(data_a), .mem_wren(wren_a),
        .sample_count(cnt_a), .busy(busy_a), .done(done_a));

    audio_capture #(.DEPTH(8), .ADDR_W(16), .DECIM(4)) dut_b (
        .CLOCK_50(clk), .reset(reset), .start(start_b), .stop(stop), .loop_en(loop_en),
        .audio_in_available(avail), .left_channel_audio_in(l_in), .right_channel_audio_in(r_in),
        .read_audio_in(rd_b), .mem_address(addr_b), .mem_data(data_b), .mem_wren(wren_b),
        .sample_count(cnt_b), .busy(busy_b), .done(done_b));

    audio_capture #(.DEPTH(4), .ADDR_W(16), .DECIM(1)) dut_c (
        .CLOCK_50(clk), .reset(reset), .start(start_c), .stop(stop), .loop_en(loop_en),
        .audio_in_available(avail), .left_channel_audio_in(l_in), .right_channel_audio_in(r_in),
        .read_audio_in(rd_c), .mem_address(addr_c), .mem_data(data_c), .mem_wren(wren_c),
        .sample_count(cnt_c), .busy(busy_c), .done(done_c));

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic cmp_wr(string nm, exp_t e, logic [15:0] a, logic [15:0] d);
        check({nm, "_addr"}, 32'(a), 32'(e.addr));
        check({nm, "_data"}, 32'(d), 32'(e.data));
        check({nm, "_cycle"}, 32'(cyc), 32'(e.wcyc));
    endtask

    task automatic unexpected(string nm, logic [15:0] a, logic [15:0] d);
        checks++;
        failures++;
        $display("FAIL %s actual=write@%0h:%0h required=no write", nm, a, d);
    endtask

    // Scoreboard consumers: every strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (wren_a === 1'b1) begin
            if (qa.size() == 0) unexpected("wr_a_extra", addr_a, data_a);
            else cmp_wr("wr_a", qa.pop_front(), addr_a, data_a);
        end
        if (wren_b === 1'b1) begin
            if (qb.size() == 0) unexpected("wr_b_extra", addr_b, data_b);
            else cmp_wr("wr_b", qb.pop_front(), addr_b, data_b);
        end
        if (wren_c === 1'b1) begin
            if (qc.size() == 0) unexpected("wr_c_extra", addr_c, data_c);
            else cmp_wr("wr_c", qc.pop_front(), addr_c, data_c);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Write is due one cycle after the accept edge that follows this drive.
    task automatic expect_wr(int id, logic [15:0] a, logic [15:0] d);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.wcyc = cyc + 1;
        if (id == 0) qa.push_back(e);
        else if (id == 1) qb.push_back(e);
        else qc.push_back(e);
    endtask

    task automatic send(logic [31:0] l, logic [31:0] r);
        avail = 1'b1;
        l_in  = l;
        r_in  = r;
        step();
        avail = 1'b0;
    endtask

    task automatic pulse_start(int id);
        if (id == 0) start_a = 1'b1;
        else if (id == 1) start_b = 1'b1;
        else start_c = 1'b1;
        step();
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic drain(string nm);
        for (int i = 0; i < 20 && (qa.size() + qb.size() + qc.size()) > 0; i++)
            step();
        step();
        check(nm, 32'(qa.size() + qb.size() + qc.size()), 32'd0);
    endtask

    initial begin
        tbl[0] = '{32'h0001_0000, 32'h0001_0000, 16'h0004};
        tbl[1] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 16'h7FFF};
        tbl[2] = '{32'h8000_0000, 32'h8000_0000, 16'h8000};
        tbl[3] = '{32'h0004_0000, 32'hFFFC_0000, 16'h0000};
        tbl[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'hFFFF};
        tbl[5] = '{32'h0020_0000, 32'h0000_0000, 16'h0040};
        tbl[6] = '{32'h1FFF_C000, 32'h1FFF_C000, 16'h7FFF};
        tbl[7] = '{32'hE000_0000, 32'hE000_0000, 16'h8000};

        reset = 1'b1; start_a = 0; start_b = 0; start_c = 0; stop = 0;
        loop_en = 0; avail = 0; l_in = '0; r_in = '0;
        step();
        step();

        // Reset state and the combinational codec pop.
        avail = 1'b1;
        #1;
        check("rd_in_reset", 32'(rd_a), 32'd0);
        check("wren_in_reset", 32'(wren_a), 32'd0);
        reset = 1'b0;
        #1;
        check("rd_avail", 32'(rd_a), 32'd1);
        avail = 1'b0;
        #1;
        check("rd_idle_noavail", 32'(rd_a), 32'd0);
        check("rst_addr", 32'(addr_a), 32'd0);
        check("rst_data", 32'(data_a), 32'd0);
        check("rst_count", 32'(cnt_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);

        // One-shot capture over the mix table, then 2 surplus pairs.
        pulse_start(0);
        check("a_busy_start", 32'(busy_a), 32'd1);
        for (int i = 0; i < 8; i++) begin
            expect_wr(0, 16'(i), tbl[i].d);
            send(tbl[i].l, tbl[i].r);
        end
        send(32'h0001_0000, 32'h0001_0000);
        send(32'h0001_0000, 32'h0001_0000);
        drain("a_drain");
        check("a_done", 32'(done_a), 32'd1);
        check("a_busy_done", 32'(busy_a), 32'd0);
        check("a_count8", 32'(cnt_a), 32'd8);

        // Decimate by 4: pairs 0, 4, 8 kept.
        pulse_start(1);
        for (int k = 0; k < 12; k++) begin
            if (k % 4 == 0) expect_wr(1, 16'(k / 4), 16'(4 * k));
            send(32'(k) << 16, 32'(k) << 16);
        end
        drain("b_drain");
        check("b_count3", 32'(cnt_b), 32'd3);
        check("b_busy", 32'(busy_b), 32'd1);
        pulse_stop();
        check("b_stopped", 32'(busy_b), 32'd0);

        // Looping capture wraps and saturates the count.
        loop_en = 1'b1;
        pulse_start(2);
        for (int k = 0; k < 6; k++) begin
            expect_wr(2, 16'(k % 4), 16'(4 * (k + 1)));
            send(32'(k + 1) << 16, 32'(k + 1) << 16);
        end
        drain("c_drain");
        check("c_done_low", 32'(done_c), 32'd0);
        check("c_count_sat", 32'(cnt_c), 32'd4);
        check("c_busy", 32'(busy_c), 32'd1);
        pulse_stop();
        loop_en = 1'b0;
        check("c_stopped", 32'(busy_c), 32'd0);

        // Stop lands in the write cycle of the 3rd sample.
        pulse_start(0);
        check("a_restart_done", 32'(done_a), 32'd0);
        check("a_restart_count", 32'(cnt_a), 32'd0);
        for (int k = 0; k < 3; k++) begin
            expect_wr(0, 16'(k), 16'(4 * (k + 1)));
            send(32'(k + 1) << 16, 32'(k + 1) << 16);
        end
        pulse_stop();
        check("stop_wr_done", 32'(qa.size()), 32'd0);
        check("stop_busy", 32'(busy_a), 32'd0);
        check("stop_done", 32'(done_a), 32'd0);
        check("stop_count3", 32'(cnt_a), 32'd3);

        // Simultaneous start and stop from IDLE: stop wins.
        start_a = 1'b1;
        stop    = 1'b1;
        step();
        start_a = 1'b0;
        stop    = 1'b0;
        check("startstop_busy", 32'(busy_a), 32'd0);
        check("startstop_count", 32'(cnt_a), 32'd3);

        // Reset in the write cycle of the 2nd sample cancels that write.
        pulse_start(0);
        expect_wr(0, 16'd0, 16'h0008);
        send(32'h0002_0000, 32'h0002_0000);
        send(32'h0005_0000, 32'h0005_0000);
        reset = 1'b1;
        #1;
        check("rst_wr_cancel", 32'(wren_a), 32'd0);
        step();
        reset = 1'b0;
        #1;
        check("rst2_queue", 32'(qa.size()), 32'd0);
        check("rst2_addr", 32'(addr_a), 32'd0);
        check("rst2_data", 32'(data_a), 32'd0);
        check("rst2_count", 32'(cnt_a), 32'd0);
        check("rst2_busy", 32'(busy_a), 32'd0);
        check("rst2_done", 32'(done_a), 32'd0);

        pulse_start(0);
        expect_wr(0, 16'd0, 16'h000C);
        send(32'h0003_0000, 32'h0003_0000);
        drain("post_rst_drain");
        check("post_rst_count", 32'(cnt_a), 32'd1);
        check("post_rst_busy", 32'(busy_a), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
